// File: rtl/keypad_pkg.sv
// Shared keypad constants, column state encoding and the bit-index to key-code map.
// Snapshot bit index is col*NUM_ROWS + row.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    COL_0 = 2'd0,
    COL_1 = 2'd1,
    COL_2 = 2'd2
  } col_state_e;

  function automatic logic [3:0] bit_to_code(input int idx);
    logic [3:0] code;
    case (idx)
      0:       code = 4'd1;
      1:       code = 4'd4;
      2:       code = 4'd7;
      3:       code = KEY_STAR;
      4:       code = 4'd2;
      5:       code = 4'd5;
      6:       code = 4'd8;
      7:       code = 4'd0;
      8:       code = 4'd3;
      9:       code = 4'd6;
      10:      code = 4'd9;
      11:      code = KEY_HASH;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_encode.sv
// Combinational decode of a 12-bit keypad state: flags a single pressed key
// and returns the code of the lowest set bit.
module keypad_encode
  import keypad_pkg::*;
(
  input  logic [NUM_KEYS-1:0] state,
  output logic                one_hot,
  output logic [3:0]          code
);

  always_comb begin
    code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (state[i]) code = bit_to_code(i);
    end
  end

  assign one_hot = (state != '0) && ((state & (state - 1'b1)) == '0);

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad column scanner with row synchronizer, whole-scan debounce and
// single-cycle key events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk_1,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] key_row,
  output logic [NUM_COLS-1:0] key_col,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_held,
  output col_state_e          scan_state
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [DIV_W-1:0]    div_cnt;
  col_state_e          col_state, col_next;
  logic [NUM_ROWS-1:0] row_s1, row_s2;
  logic [NUM_KEYS-1:0] snapshot, snap_full, raw_prev, deb;
  logic [STAB_W-1:0]   stab_cnt;
  logic                col_done, scan_end;
  logic                new_one_hot;
  logic [3:0]          new_code;

  assign col_done   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_end   = col_done && (col_state == COL_2);
  assign scan_state = col_state;

  // Snapshot with the current column's synced rows merged in, so the scan-end
  // comparison sees column 2 in the same cycle it is sampled.
  always_comb begin
    snap_full = snapshot;
    case (col_state)
      COL_0:   snap_full[0*NUM_ROWS +: NUM_ROWS] = row_s2;
      COL_1:   snap_full[1*NUM_ROWS +: NUM_ROWS] = row_s2;
      COL_2:   snap_full[2*NUM_ROWS +: NUM_ROWS] = row_s2;
      default: snap_full = snapshot;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) col_state <= COL_0;
    else      col_state <= col_next;
  end

  always_comb begin
    col_next = col_state;
    key_col  = 3'b001;
    case (col_state)
      COL_0: begin
        key_col = 3'b001;
        if (col_done) col_next = COL_1;
      end
      COL_1: begin
        key_col = 3'b010;
        if (col_done) col_next = COL_2;
      end
      COL_2: begin
        key_col = 3'b100;
        if (col_done) col_next = COL_0;
      end
      default: begin
        key_col  = 3'b001;
        col_next = COL_0;
      end
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      row_s1   <= '0;
      row_s2   <= '0;
      snapshot <= '0;
    end else begin
      div_cnt <= col_done ? '0 : div_cnt + 1'b1;
      row_s1  <= key_row;
      row_s2  <= row_s1;
      if (col_done) snapshot <= snap_full;
    end
  end

  keypad_encode u_encode (
    .state   (raw_prev),
    .one_hot (new_one_hot),
    .code    (new_code)
  );

  // key_valid is a one-cycle strobe with no back-pressure: the consumer must
  // take key_code in the cycle key_valid is high; key_code then holds.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      raw_prev  <= '0;
      stab_cnt  <= '0;
      deb       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        if (snap_full != raw_prev) begin
          raw_prev <= snap_full;
          stab_cnt <= STAB_W'(1);
        end else if (stab_cnt < STAB_W'(DEBOUNCE_SCANS)) begin
          stab_cnt <= stab_cnt + 1'b1;
          if (stab_cnt == STAB_W'(DEBOUNCE_SCANS - 1)) begin
            deb      <= raw_prev;
            key_held <= (raw_prev != '0);
            // Only a clean transition from nothing to one key is an event.
            if ((deb == '0) && new_one_hot) begin
              key_valid <= 1'b1;
              key_code  <= new_code;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scan-level bench for keypad_scanner: per-scan key sets drive a keypad model,
// a reference debouncer predicts events, and a monitor checks each pulse.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD       = 4;
  localparam int DS       = 3;
  localparam int SCAN_CYC = 3 * SD;

  logic       clk_1 = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  col_state_e scan_state;

  logic [11:0] pressed = '0;  // bit c*4+r

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cyc   = '0;

  logic [3:0]  exp_code_q[$];
  logic [31:0] exp_cyc_q[$];

  logic [11:0] m_last = '0;
  logic [11:0] m_deb  = '0;
  int          m_run  = 0;
  logic [3:0]  m_code = '0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk_1      (clk_1),
    .rst        (rst),
    .key_row    (key_row),
    .key_col    (key_col),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_held   (key_held),
    .scan_state (scan_state)
  );

  // clock / keypad model
  always #5 clk_1 = ~clk_1;
  always @(posedge clk_1) cyc <= cyc + 32'd1;

  always_comb begin
    key_row = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && key_col[c]) key_row[r] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(input int r, input int c);
    if (r < 3) return 4'(r * 3 + c + 1);
    if (c == 0) return 4'd10;
    if (c == 1) return 4'd0;
    return 4'd11;
  endfunction

  function automatic logic [11:0] key_bit(input int r, input int c);
    logic [11:0] v;
    v = '0;
    v[c*4+r] = 1'b1;
    return v;
  endfunction

  // reference: a key set seen on DS consecutive scans becomes the accepted state
  task automatic model_scan(input logic [11:0] s);
    if (s == m_last) m_run++;
    else begin
      m_last = s;
      m_run  = 1;
    end
    if (m_run == DS) begin
      if (m_deb == '0 && $countones(s) == 1) begin
        for (int i = 0; i < 12; i++)
          if (s[i]) m_code = code_of(i % 4, i / 4);
        exp_code_q.push_back(m_code);
        exp_cyc_q.push_back(cyc + 32'(SCAN_CYC));
      end
      m_deb = s;
    end
  endtask

  task automatic model_reset();
    m_last = '0;
    m_deb  = '0;
    m_run  = 0;
    m_code = '0;
  endtask

  // driver: one full scan with the given key set held throughout
  task automatic run_scan(input logic [11:0] s);
    check("key_held", 32'(key_held), 32'(m_deb != '0));
    check("key_code_hold", 32'(key_code), 32'(m_code));
    pressed = s;
    model_scan(s);
    for (int i = 0; i < SCAN_CYC; i++) begin
      check("key_col", 32'(key_col), 32'(3'b001 << (i / SD)));
      @(negedge clk_1);
    end
  endtask

  task automatic run_scans(input logic [11:0] s, input int n);
    for (int k = 0; k < n; k++) run_scan(s);
  endtask

  // scoreboard monitor
  always @(negedge clk_1) begin
    if (rst && key_valid) begin
      if (exp_code_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got code %0d expected no pulse at %0t", key_code, $time);
      end else begin
        logic [3:0]  ec;
        logic [31:0] et;
        ec = exp_code_q.pop_front();
        et = exp_cyc_q.pop_front();
        check("event_code", 32'(key_code), 32'(ec));
        check("event_cycle", cyc, et);
      end
    end
  end

  initial begin
    int kind, len;
    logic [11:0] s;

    repeat (3) @(negedge clk_1);
    check("rst_key_col", 32'(key_col), 32'(3'b001));
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    rst = 1'b1;

    // idle scanning
    run_scans('0, 4);

    // long hold of '2', then release
    run_scans(key_bit(0, 1), 20);
    run_scans('0, 5);

    // '0' then '#'
    run_scans(key_bit(3, 1), 4);
    run_scans('0, 4);
    run_scans(key_bit(3, 2), 4);
    run_scans('0, 4);

    // bouncing '4'
    for (int k = 0; k < 10; k++) run_scan((k % 2 == 0) ? key_bit(1, 0) : 12'd0);
    run_scans('0, 2);

    // two keys, drop to one, release, then '9'
    run_scans(key_bit(0, 0) | key_bit(2, 2), 5);
    run_scans(key_bit(0, 0), 5);
    run_scans('0, 4);
    run_scans(key_bit(2, 2), 4);
    run_scans('0, 4);

    // '6' held through a mid-scan reset
    run_scans(key_bit(1, 2), 4);
    repeat (5) @(negedge clk_1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_key_col", 32'(key_col), 32'(3'b001));
    check("mid_rst_key_valid", 32'(key_valid), 32'd0);
    check("mid_rst_key_code", 32'(key_code), 32'd0);
    check("mid_rst_key_held", 32'(key_held), 32'd0);
    check("mid_rst_queue", 32'(exp_code_q.size()), 32'd0);
    repeat (2) @(negedge clk_1);
    model_reset();
    rst = 1'b1;
    run_scans(key_bit(1, 2), 5);
    run_scans('0, 4);

    // random key sets with random run lengths
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      s    = '0;
      if (kind >= 1) s = key_bit($urandom_range(0, 3), $urandom_range(0, 2));
      if (kind == 3) s = s | key_bit($urandom_range(0, 3), $urandom_range(0, 2));
      run_scans(s, len);
    end
    run_scans('0, 4);

    check("pending_events", 32'(exp_code_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
